// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin sharing of one clocked ALU between two requesters.
//             Each requester has a valid/ready request channel and a
//             valid/ready response channel. One operation is in flight at a
//             time: IDLE -> EXEC (ALU_LAT+1 cycles) -> RESP -> IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int XLEN    = 32,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*XLEN-1:0] req_rs1,
  input  logic [2*XLEN-1:0] req_rs2,
  input  logic [5:0]        req_funct3,
  input  logic [1:0]        req_funct7,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_rd,
  output logic              rsp_z,
  output logic [XLEN-1:0]   alu_rs1,
  output logic [XLEN-1:0]   alu_rs2,
  output logic [2:0]        alu_funct3,
  output logic              alu_funct7,
  input  logic [XLEN-1:0]   alu_rd,
  input  logic              alu_z,
  output logic              busy
);

  localparam int            C_CW  = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [C_CW-1:0] C_LAT = C_CW'(ALU_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_prio;
  logic            r_grant;
  logic [C_CW-1:0] r_cnt;

  logic            w_gnt;
  logic            w_accept;
  logic            w_rsp_fire;

  // Grant selection: contested cycles go to the priority port, otherwise to
  // whichever port is requesting. Flush in IDLE blocks acceptance.
  always_comb begin
    w_gnt      = (&req_valid) ? r_prio : req_valid[1];
    w_accept   = (r_state == S_IDLE) && !flush && (|req_valid);
    w_rsp_fire = (r_state == S_RESP) && (|(rsp_valid & rsp_ready));
    req_ready  = 2'b00;
    // rst_n gating keeps req_ready low while reset is held, without a clock
    if (rst_n && w_accept) begin
      req_ready = w_gnt ? 2'b10 : 2'b01;
    end
  end

  // Arbitration FSM with registered ALU drive, response capture and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_prio     <= 1'b0;
      r_grant    <= 1'b0;
      r_cnt      <= '0;
      rsp_valid  <= 2'b00;
      rsp_rd     <= '0;
      rsp_z      <= 1'b0;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
      alu_funct3 <= 3'b000;
      alu_funct7 <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            alu_rs1    <= w_gnt ? req_rs1[XLEN +: XLEN] : req_rs1[0 +: XLEN];
            alu_rs2    <= w_gnt ? req_rs2[XLEN +: XLEN] : req_rs2[0 +: XLEN];
            alu_funct3 <= w_gnt ? req_funct3[5:3] : req_funct3[2:0];
            alu_funct7 <= w_gnt ? req_funct7[1] : req_funct7[0];
            r_grant    <= w_gnt;
            r_cnt      <= C_LAT;
            busy       <= 1'b1;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (flush) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            // ALU output has settled: capture it for the response phase
            rsp_rd    <= alu_rd;
            rsp_z     <= alu_z;
            rsp_valid <= r_grant ? 2'b10 : 2'b01;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (flush) begin
            // result discarded, priority left where it was
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_rsp_fire) begin
            r_prio    <= ~r_grant;
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single clocked ALU between two requesters, e.g. port 0 = execute stage and port 1 = branch/address unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; only one operation is in flight at a time.
- Sits between the requesters and the ALU instance. It drives the ALU operand/opcode inputs and captures the ALU result and zero flag.

Parameters:
XLEN, 32, operand/result width
ALU_LAT, 1, ALU clock edges from operand change to valid rd/z (0 = combinational ALU)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of in-flight op
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester request accepted
req_rs1  in  2*XLEN  operand A; port i at [i*XLEN +: XLEN]
req_rs2  in  2*XLEN  operand B, same packing
req_funct3  in  6  opcode; port i at [i*3 +: 3]
req_funct7  in  2  per-port funct7 bit (sub/sra select)
rsp_valid  out  2  per-requester result valid
rsp_ready  in  2  per-requester result accepted
rsp_rd  out  XLEN  result (shared bus; qualified by rsp_valid)
rsp_z  out  1  zero flag from ALU, passed unmodified
alu_rs1  out  XLEN  to ALU rs1
alu_rs2  out  XLEN  to ALU rs2
alu_funct3  out  3  to ALU funct3
alu_funct7  out  1  to ALU funct7
alu_rd  in  XLEN  from ALU rd
alu_z  in  1  from ALU z
busy  out  1  high in EXEC or RESP

Behaviour:
Reset:
- Clock is clk; reset is asynchronous, active-low, on rst_n.
- On reset assertion: state=IDLE, prio=0, grant=0, exec counter=0.
- On reset assertion, all outputs are 0 immediately: req_ready, rsp_valid, rsp_rd, rsp_z, alu_*, busy.

FSM: IDLE -> EXEC -> RESP -> IDLE.

IDLE:
- Grant selection: if both req_valid are high, grant=prio; if only one is high, grant that one.
- req_ready[grant] is high combinationally; the other req_ready is 0.
- Acceptance occurs on the edge where req_valid[g]&req_ready[g]. On that edge:
  - Latch rs1/rs2/funct3/funct7 into the alu_* registers.
  - grant<=g, counter<=ALU_LAT, go to EXEC.
- No valid request: remain in IDLE; alu_* hold their last values.

EXEC:
- req_ready=0.
- Lasts exactly ALU_LAT+1 cycles; counter decrements each cycle.
- On the final EXEC edge: rsp_rd<=alu_rd, rsp_z<=alu_z, go to RESP.

RESP:
- rsp_valid[grant]=1; the other rsp_valid=0; req_ready=0.
- rsp_rd and rsp_z are held stable while rsp_ready[grant]=0. rsp_ready of the non-granted port is ignored.
- On the edge where rsp_valid[grant]&rsp_ready[grant]: prio<=~grant, go to IDLE.
- No new request is accepted in the handshake cycle.

Latency (accept cycle = cycle 0):
- rsp_valid is first high in cycle ALU_LAT+2; cycle 3 at the default ALU_LAT=1.
- Peak throughput is one op per ALU_LAT+3 cycles.

flush:
- In EXEC or RESP: go to IDLE on the next edge; rsp_valid drops; prio unchanged; the result is discarded.
- In IDLE: flush has priority over acceptance; req_ready=0 in that cycle.

Other rules:
- rsp_rd and rsp_z retain their last value outside RESP.
- Reset asserted mid-operation: the op is lost and outputs go to reset values asynchronously.
- A requester may drop req_valid before acceptance with no effect.
- Operands are sampled only on the accept edge. Later changes on req_* do not affect the in-flight op.

Test Plan:
- After reset, only req0 valid, ADD: rs1=20, rs2=30, funct3=000, funct7=0, rsp_ready=11 -> req_ready=01 in cycle 0; busy in cycles 1-3; rsp_valid=01 in cycle 3 with rsp_rd=50; IDLE in cycle 4.
- Both valid in the same cycle after reset: req0 SUB 8-3 (funct7=1), req1 AND 20&30 (funct3=111) -> req0 served first with rsp_rd=5; then req1 accepted and served with rsp_rd=20; req_ready[1]=0 throughout the first op.
- Fairness: both req_valid held high for 4 ops -> grant order 0,1,0,1; no port starved.
- Backpressure: rsp_ready[0]=0 for 5 RESP cycles -> rsp_valid=01 and rsp_rd stable, req_ready=00. Raising rsp_ready[0] completes the transfer, IDLE next cycle.
- Zero flag: SUB 20-20 -> rsp_rd=0, rsp_z equals the alu_z value sampled on the final EXEC edge.
- flush asserted in the 2nd EXEC cycle -> no rsp_valid pulse, IDLE next cycle, prio unchanged. Separately, rst_n low during RESP -> rsp_valid=00 and busy=0 immediately without a clock edge; the next op after release is served to port 0 first when both ports request.
